uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Self-contained asynchronous serial receiver for the 11-bit frame that uart_tx emits:
  - start bit 0
  - data[7:0], LSB first
  - even-parity bit = ^data
  - stop bit 1
- Runs entirely in the fclk domain with its own bit-period counter and input synchronizer.
- Delivers bytes through a one-entry holding register with a valid/ready pop handshake, plus per-frame error and sticky overrun status.
- Sits between the pad rx line and the bus-side register file as the receive end of uart_tx.

Parameters:
- CMSB, 12, MSB of the bit-period divider (div width = CMSB+1).

Ports:
- fclk  input  1  receive clock; all state is on posedge.
- rstn  input  1  reset, asynchronous, active-low.
- en  input  1  receiver enable; low aborts any frame and holds the FSM in IDLE.
- div  input  CMSB+1  fclk cycles per bit; values below 4 are treated as 4.
- rx  input  1  serial line, asynchronous to fclk.
- clear  input  1  synchronous clear of rvalid, perr, ferr and overrun.
- rready  input  1  pop strobe; consumes the holding register when rvalid=1.
- rdata  output  8  received byte.
- rvalid  output  1  holding register full.
- perr  output  1  parity error of the frame currently in rdata.
- ferr  output  1  stop bit sampled 0 for the frame currently in rdata.
- overrun  output  1  sticky: a completed frame was lost.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values: rdata=0, rvalid=0, perr=0, ferr=0, overrun=0, busy=0.
  - Synchronizer flops reset to 1 (line idle).
  - FSM resets to IDLE; cnt=0.
- rx passes through a 2-flop synchronizer; rxs denotes the synchronized value.
- Let D = max(div,4) and H = D>>1.
- States: IDLE, START, DATA, PARITY, STOP.
- Falling edge detection:
  - In IDLE with en=1, a falling edge of rxs (previous 1, current 0) moves the FSM to START with cnt=0.
- cnt counts 0..D-1 per bit and wraps at D-1.
  - The sample decision is taken at cnt==H (or H+1 with the optional feature).
- START:
  - Decision 1 (false start) → IDLE; no status change.
  - Decision 0 → continue; at wrap go to DATA with bit index 0.
- DATA:
  - The decision at the sample point is shifted into the data register LSB first.
  - At wrap after bit index 7 → PARITY.
- PARITY: capture the parity bit; at wrap → STOP.
- STOP, at the decision cycle:
  - Commit the frame and return to IDLE the same cycle, so the next start edge is accepted from mid-stop.
  - Commit values: perr_n = (^data != parity bit); ferr_n = (stop sample == 0).
- Commit is registered, so rvalid rises 1 fclk after the STOP decision. At D=16 that is 169 fclk after the START transition.
- Commit cases:
  - rvalid=0, or rready=1 in the same cycle: load rdata/perr/ferr, rvalid=1, overrun unchanged.
  - rvalid=1 and rready=0: discard the new frame, keep rdata/perr/ferr, set overrun=1.
- Pop: rready=1 with rvalid=1 and no commit → rvalid=0 next cycle. rready with rvalid=0 is ignored.
- clear has priority over pop and commit status updates. It zeroes rvalid, perr, ferr and overrun; rdata is retained. The FSM is unaffected.
- en=0: FSM → IDLE next cycle and the partial frame is discarded. The holding register and flags are kept.
- div changes mid-frame take effect at the next cnt compare; the result is undefined for that frame only.
- Frames with perr or ferr are still delivered, with their flags set.
- Line held low (break): the frame commits with ferr=1. Because a falling edge is required, no new START occurs until rxs returns to 1.

Optional Feature:
- Macro: UART_FRAME_RX_MAJORITY_EN.
- Defined:
  - Each bit is sampled at cnt=H-1, H and H+1.
  - The decision is the 2-of-3 majority, taken at cnt==H+1.
  - The start-bit false-start check uses the same majority.
- Undefined: single sample at cnt==H; the decision is at cnt==H.

Decomposition:
- Shared package/header:
  - FSM state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits).
  - Frame constants: DATA_BITS=8, FRAME_BITS=11, MIN_DIV=4.
  - Parity function (even, ^data).
- Sub-module uart_rx_sampler:
  - 2-flop synchronizer, falling-edge detect.
  - Optional 3-sample majority, with a decision-valid strobe at the sample point.
- The top level holds the FSM, cnt, shift register, holding register and flags.

Test Plan:
- div=16, frame 0xA5 (parity 0, stop 1) → rdata=0xA5, rvalid=1, perr=0, ferr=0, 169 fclk after START; rready pulse → rvalid=0.
- div=16, 0x01 sent with parity bit 0 (wrong; ^0x01=1) → rdata=0x01, perr=1, ferr=0.
- div=16, 0x3C with stop=0, then line held low → rdata=0x3C, ferr=1; no new frame until rx high then falling edge.
- Two frames 0x11 then 0x22 back to back, no rready → rdata=0x11, overrun=1. Repeat with rready pulsed exactly on the second commit cycle → rdata=0x22, rvalid=1, overrun=0.
- rx low pulse of 4 fclk at div=16 → FSM START→IDLE, rvalid stays 0. Then en dropped mid-DATA of 0x5A → busy=0 next cycle, no commit. Then clear → all flags 0.
- Async rstn asserted mid-DATA → all outputs at reset values immediately. div=2 behaves identically to div=4 (0xC3 received correctly at 4 fclk/bit).

Source files
------------

// File: rtl/uart_frame_rx_pkg.sv
// Shared encodings, frame constants and parity helper for the uart_frame_rx receiver.
// The optional 3-sample majority vote is enabled with UART_FRAME_RX_MAJORITY_EN.
package uart_frame_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;
   localparam int MIN_DIV    = 4;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, falling-edge detect and per-bit sample decision for uart_frame_rx.
// With UART_FRAME_RX_MAJORITY_EN the decision is a 2-of-3 vote over cnt = H-1, H, H+1.
module uart_rx_sampler
   import uart_frame_rx_pkg::*;
#(
   parameter int CMSB = 12
) (
   input  logic        fclk,
   input  logic        rstn,
   input  logic        rx,
   input  logic [CMSB:0] cnt,
   input  logic [CMSB:0] half,
   output logic        fall,
   output logic        stb,
   output logic        bit_val
);

   localparam logic [CMSB:0] ONE = (CMSB+1)'(1);

   logic [1:0] sync_q;
   logic       rxs_d;
   logic       rxs;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge fclk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= 2'b11;
         rxs_d  <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], rx};
         rxs_d  <= sync_q[1];
      end
   end

   assign rxs  = sync_q[1];
   assign fall = rxs_d & ~rxs;

`ifdef UART_FRAME_RX_MAJORITY_EN
   logic s0, s1;

   always_ff @(posedge fclk or negedge rstn) begin
      if (!rstn) begin
         s0 <= 1'b1;
         s1 <= 1'b1;
      end else begin
         if (cnt == half - ONE) s0 <= rxs;
         if (cnt == half)       s1 <= rxs;
      end
   end

   // Third vote is the live sample at H+1, so the decision lands on that cycle.
   assign stb     = (cnt == half + ONE);
   assign bit_val = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
`else
   assign stb     = (cnt == half);
   assign bit_val = rxs;
`endif

endmodule

// File: rtl/uart_frame_rx.sv
// Receive end of uart_tx: 11-bit frame (start, 8 data LSB first, even parity, stop) into a
// one-entry holding register with pop handshake. Optional majority sampling: UART_FRAME_RX_MAJORITY_EN.
module uart_frame_rx
   import uart_frame_rx_pkg::*;
#(
   parameter int CMSB = 12
) (
   input  logic          fclk,
   input  logic          rstn,
   input  logic          en,
   input  logic [CMSB:0] div,
   input  logic          rx,
   input  logic          clear,
   input  logic          rready,
   output logic [7:0]    rdata,
   output logic          rvalid,
   output logic          perr,
   output logic          ferr,
   output logic          overrun,
   output logic          busy
);

   localparam logic [CMSB:0] MIN_D = (CMSB+1)'(MIN_DIV);
   localparam logic [CMSB:0] ONE   = (CMSB+1)'(1);
   localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

   rx_state_e           state;
   logic [CMSB:0]       cnt;
   logic [2:0]          bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                par_bit;

   logic [CMSB:0] d_eff;
   logic [CMSB:0] half;
   logic          wrap;
   logic          fall, stb, bit_val;
   logic          commit;
   logic          perr_n, ferr_n;

   assign d_eff = (div < MIN_D) ? MIN_D : div;
   assign half  = d_eff >> 1;
   assign wrap  = (cnt == d_eff - ONE);

   uart_rx_sampler #(.CMSB(CMSB)) u_sampler (
      .fclk    (fclk),
      .rstn    (rstn),
      .rx      (rx),
      .cnt     (cnt),
      .half    (half),
      .fall    (fall),
      .stb     (stb),
      .bit_val (bit_val)
   );

   assign commit = en && (state == ST_STOP) && stb;
   assign perr_n = (even_parity(shreg) != par_bit);
   assign ferr_n = ~bit_val;
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge fclk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else if (!en) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state <= ST_START;
                  cnt   <= '0;
               end
            end
            ST_START: begin
               cnt <= wrap ? '0 : cnt + ONE;
               if (stb && bit_val) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (wrap) begin
                  state   <= ST_DATA;
                  bit_idx <= '0;
               end
            end
            ST_DATA: begin
               cnt <= wrap ? '0 : cnt + ONE;
               if (stb) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
               if (wrap) begin
                  if (bit_idx == LAST_IDX) state <= ST_PARITY;
                  else                     bit_idx <= bit_idx + 3'd1;
               end
            end
            ST_PARITY: begin
               cnt <= wrap ? '0 : cnt + ONE;
               if (stb)  par_bit <= bit_val;
               if (wrap) state   <= ST_STOP;
            end
            ST_STOP: begin
               cnt <= wrap ? '0 : cnt + ONE;
               // Leave mid-stop so a start edge right at the end of the stop bit is caught.
               if (stb) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge fclk or negedge rstn) begin
      if (!rstn) begin
         rdata   <= '0;
         rvalid  <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         overrun <= 1'b0;
      end else if (clear) begin
         rvalid  <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         overrun <= 1'b0;
      end else if (commit) begin
         if (!rvalid || rready) begin
            rdata  <= shreg;
            perr   <= perr_n;
            ferr   <= ferr_n;
            rvalid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (rready && rvalid) begin
         rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: frames driven bit-by-bit, expected bytes queued in a
// scoreboard and compared on delivery. Latency expectation follows UART_FRAME_RX_MAJORITY_EN.
module tb_uart_frame_rx;
   import uart_frame_rx_pkg::*;

   localparam int CMSB = 12;
`ifdef UART_FRAME_RX_MAJORITY_EN
   localparam int LAT = 170;
`else
   localparam int LAT = 169;
`endif
   localparam int TMO = 3000;

   logic          fclk = 1'b0;
   logic          rstn, en, rx, clear, rready;
   logic [CMSB:0] div;
   logic [7:0]    rdata;
   logic          rvalid, perr, ferr, overrun, busy;

   uart_frame_rx #(.CMSB(CMSB)) dut (
      .fclk    (fclk),
      .rstn    (rstn),
      .en      (en),
      .div     (div),
      .rx      (rx),
      .clear   (clear),
      .rready  (rready),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .perr    (perr),
      .ferr    (ferr),
      .overrun (overrun),
      .busy    (busy)
   );

   always #5 fclk = ~fclk;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       f;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int deff(input int d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge fclk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic p, input logic f);
      exp_t e;
      e.d = d;
      e.p = p;
      e.f = f;
      sb.push_back(e);
   endtask

   // Bits go out LSB first: start, data[0..7], parity, stop.
   task automatic send_bits(input logic [FRAME_BITS-1:0] bits, input int nbits, input int dv);
      for (int i = 0; i < nbits; i++) begin
         rx = bits[i];
         step(deff(dv));
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int dv);
      send_bits({stp, par, d, 1'b0}, FRAME_BITS, dv);
      rx = 1'b1;
   endtask

   task automatic wait_busy(input logic lvl, input string tag);
      int n = 0;
      while (busy !== lvl && n < TMO) begin
         step(1);
         n++;
      end
      if (n >= TMO) check({tag, ".busy_tmo"}, busy, lvl);
   endtask

   task automatic expect_pop(input string tag);
      exp_t e;
      int   n = 0;
      while (rvalid !== 1'b1 && n < TMO) begin
         step(1);
         n++;
      end
      check({tag, ".rvalid"}, rvalid, 1);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      check({tag, ".rdata"}, rdata, e.d);
      check({tag, ".perr"}, perr, e.p);
      check({tag, ".ferr"}, ferr, e.f);
      rready = 1'b1;
      step(1);
      rready = 1'b0;
      check({tag, ".popped"}, rvalid, 0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   initial begin
      int   c;
      exp_t e;

      rstn = 1'b0; en = 1'b1; rx = 1'b1; clear = 1'b0; rready = 1'b0;
      div  = (CMSB+1)'(16);
      #1;
      check("rst.rdata", rdata, 0);
      check("rst.rvalid", rvalid, 0);
      check("rst.flags", {perr, ferr, overrun}, 0);
      check("rst.busy", busy, 0);
      step(3);
      rstn = 1'b1;
      step(4);

      // Good frame with latency measurement from START.
      push_exp(8'hA5, 1'b0, 1'b0);
      fork
         send_frame(8'hA5, 1'b0, 1'b1, 16);
         begin
            wait_busy(1'b1, "t1");
            c = 0;
            while (rvalid !== 1'b1 && c < TMO) begin
               step(1);
               c++;
            end
            check("t1.latency", c, LAT);
         end
      join
      expect_pop("t1");

      // Wrong parity bit.
      push_exp(8'h01, 1'b1, 1'b0);
      send_frame(8'h01, 1'b0, 1'b1, 16);
      expect_pop("t2");

      // Stop bit 0 then line held low: ferr, and no restart while low.
      push_exp(8'h3C, 1'b0, 1'b1);
      send_bits({1'b0, 1'b0, 8'h3C, 1'b0}, FRAME_BITS, 16);
      rx = 1'b0;
      step(64);
      check("t3.break_idle", busy, 0);
      expect_pop("t3");
      rx = 1'b1;
      step(20);
      check("t3.high_idle", busy, 0);
      push_exp(8'h77, 1'b0, 1'b0);
      send_frame(8'h77, 1'b0, 1'b1, 16);
      expect_pop("t3b");

      // Back-to-back without pop: second frame lost, overrun set.
      push_exp(8'h11, 1'b0, 1'b0);
      send_frame(8'h11, 1'b0, 1'b1, 16);
      send_frame(8'h22, 1'b0, 1'b1, 16);
      step(4);
      check("t4.overrun", overrun, 1);
      expect_pop("t4");
      pulse_clear();
      check("t4.clr_ovr", overrun, 0);

      // Pop exactly on the second commit cycle: new frame loads, no overrun.
      push_exp(8'h11, 1'b0, 1'b0);
      push_exp(8'h22, 1'b0, 1'b0);
      fork
         begin
            send_frame(8'h11, 1'b0, 1'b1, 16);
            send_frame(8'h22, 1'b0, 1'b1, 16);
         end
         begin
            wait_busy(1'b1, "t4b.s1");
            wait_busy(1'b0, "t4b.i1");
            wait_busy(1'b1, "t4b.s2");
            step(LAT - 1);
            e = '0;
            if (sb.size() > 0) e = sb.pop_front();
            check("t4b.first", rdata, e.d);
            rready = 1'b1;
            step(1);
            rready = 1'b0;
            check("t4b.rvalid", rvalid, 1);
            check("t4b.overrun", overrun, 0);
         end
      join
      expect_pop("t4b");

      // Short glitch: false start returns to IDLE.
      rx = 1'b0;
      step(4);
      rx = 1'b1;
      check("t5.glitch_start", busy, 1);
      step(20);
      check("t5.glitch_idle", busy, 0);
      check("t5.glitch_rvalid", rvalid, 0);

      // en dropped mid-DATA: frame discarded.
      fork
         send_frame(8'h5A, 1'b0, 1'b1, 16);
         begin
            wait_busy(1'b1, "t5");
            step(48);
            en = 1'b0;
            step(1);
            check("t5.en_busy", busy, 0);
         end
      join
      step(4);
      en = 1'b1;
      step(20);
      check("t5.en_nocommit", rvalid, 0);

      // Build up perr + overrun, then clear.
      send_frame(8'h01, 1'b0, 1'b1, 16);
      send_frame(8'h22, 1'b0, 1'b1, 16);
      step(4);
      check("t5.pre_flags", {rvalid, perr, ferr, overrun}, 4'b1101);
      pulse_clear();
      check("t5.clr_flags", {rvalid, perr, ferr, overrun}, 4'b0000);
      check("t5.clr_rdata", rdata, 8'h01);

      // Asynchronous reset mid-DATA.
      fork
         send_frame(8'hC3, 1'b0, 1'b1, 16);
         begin
            wait_busy(1'b1, "t6");
            step(40);
            #1 rstn = 1'b0;
            #1;
            check("t6.rst_rdata", rdata, 0);
            check("t6.rst_state", {rvalid, perr, ferr, overrun, busy}, 0);
         end
      join
      step(2);
      rstn = 1'b1;
      step(4);

      // div below the floor runs at 4 fclk per bit.
      div = (CMSB+1)'(2);
      push_exp(8'hC3, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b1, 2);
      expect_pop("t6.div2");
      step(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
